// File: rtl/chan_mux_arb.sv
// N-channel valid/ready mux: external select or round-robin grant, registered output beat.
// Latency: one cycle from input transfer to out_valid. Backpressure: a held beat stalls every in_ready until out_ready.
module chan_mux_arb #(
    parameter int WIDTH  = 8,
    parameter int N      = 4,
    parameter int USE_RR = 0,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    input  logic                 out_ready
);

    logic [SELW-1:0]  g;
    logic             gv;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] g_data;

    assign can_load = !out_valid || out_ready;

    generate
        if (USE_RR == 0) begin : g_sel
            // Non-power-of-2 N leaves select codes with no channel behind them.
            assign g  = sel;
            assign gv = (int'(sel) < N);
        end else begin : g_rr
            logic [SELW-1:0] ptr;
            logic            unused_sel;

            assign unused_sel = ^sel;
            assign gv         = |in_valid;

            // First valid channel scanning upward from ptr with wrap.
            always_comb begin
                int  idx;
                logic found;
                g     = ptr;
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx = int'(ptr) + k;
                    if (idx >= N) idx = idx - N;
                    if (!found && in_valid[idx]) begin
                        g     = SELW'(idx);
                        found = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ptr <= '0;
                end else if (xfer) begin
                    ptr <= (int'(g) == N - 1) ? '0 : g + 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        in_ready = '0;
        if (can_load && gv && !rst) in_ready[g] = 1'b1;
    end

    assign xfer = |(in_valid & in_ready);

    always_comb begin
        g_data = '0;
        for (int i = 0; i < N; i++) begin
            if (g == SELW'(i)) g_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    // out_data/out_chan keep their last beat when the register drains empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (can_load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= g_data;
                out_chan <= g;
            end
        end
    end

endmodule

// File: tb/tb_chan_mux_arb.sv
// Directed bench: select-mode N=4, round-robin N=4 and select-mode N=3 instances on one clock/reset.
module tb_chan_mux_arb;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // select mode, N=4
    logic [3:0]  a_in_valid, a_in_ready;
    logic [31:0] a_in_data;
    logic [1:0]  a_sel, a_out_chan;
    logic        a_out_valid, a_out_ready;
    logic [7:0]  a_out_data;
    // round-robin mode, N=4
    logic [3:0]  b_in_valid, b_in_ready;
    logic [31:0] b_in_data;
    logic [1:0]  b_sel, b_out_chan;
    logic        b_out_valid, b_out_ready;
    logic [7:0]  b_out_data;
    // select mode, N=3
    logic [2:0]  c_in_valid, c_in_ready;
    logic [23:0] c_in_data;
    logic [1:0]  c_sel, c_out_chan;
    logic        c_out_valid, c_out_ready;
    logic [7:0]  c_out_data;

    chan_mux_arb #(.WIDTH(8), .N(4), .USE_RR(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .sel(a_sel), .out_valid(a_out_valid), .out_data(a_out_data), .out_chan(a_out_chan),
        .out_ready(a_out_ready)
    );
    chan_mux_arb #(.WIDTH(8), .N(4), .USE_RR(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .sel(b_sel), .out_valid(b_out_valid), .out_data(b_out_data), .out_chan(b_out_chan),
        .out_ready(b_out_ready)
    );
    chan_mux_arb #(.WIDTH(8), .N(3), .USE_RR(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
        .sel(c_sel), .out_valid(c_out_valid), .out_data(c_out_data), .out_chan(c_out_chan),
        .out_ready(c_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 4'hF; b_in_valid = 4'hF; c_in_valid = 3'h7;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 4'h0) begin errors++; $display("FAIL reset_a_in_ready got %h want 0", a_in_ready); end
        checks++;
        if (b_in_ready !== 4'h0) begin errors++; $display("FAIL reset_b_in_ready got %h want 0", b_in_ready); end
        tick();
        tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_chan !== 2'd0) begin
            errors++; $display("FAIL reset_a_out got v=%b d=%h c=%0d want 0/00/0", a_out_valid, a_out_data, a_out_chan);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== 8'h00 || b_out_chan !== 2'd0) begin
            errors++; $display("FAIL reset_b_out got v=%b d=%h c=%0d want 0/00/0", b_out_valid, b_out_data, b_out_chan);
        end
        rst = 1'b0;
        a_in_valid = '0; b_in_valid = '0; c_in_valid = '0;
        tick();
    endtask

    task automatic test_sel_basic();
        a_sel = 2'd2; a_in_valid = 4'b0100; a_in_data = 32'h00A5_0000; a_out_ready = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 4'b0100) begin errors++; $display("FAIL sel_in_ready got %b want 0100", a_in_ready); end
        tick();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 8'hA5 || a_out_chan !== 2'd2) begin
            errors++; $display("FAIL sel_load got v=%b d=%h c=%0d want 1/a5/2", a_out_valid, a_out_data, a_out_chan);
        end
    endtask

    task automatic test_sel_backpressure();
        a_out_ready = 1'b0; a_sel = 2'd1; a_in_valid = 4'b0010; a_in_data = 32'h0000_3C00;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (a_in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0000", i, a_in_ready); end
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== 8'hA5) begin
                errors++; $display("FAIL bp_hold cyc %0d got v=%b d=%h want 1/a5", i, a_out_valid, a_out_data);
            end
            tick();
        end
        a_out_ready = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b want 0010", a_in_ready); end
        tick();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 8'h3C || a_out_chan !== 2'd1) begin
            errors++; $display("FAIL bp_release_load got v=%b d=%h c=%0d want 1/3c/1", a_out_valid, a_out_data, a_out_chan);
        end
        a_in_valid = 4'b0000;
        tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 8'h3C || a_out_chan !== 2'd1) begin
            errors++; $display("FAIL drain got v=%b d=%h c=%0d want 0/3c/1", a_out_valid, a_out_data, a_out_chan);
        end
    endtask

    task automatic test_rr_all();
        b_in_data = 32'h1312_1110; b_in_valid = 4'hF; b_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int e;
            e = k % 4;
            tick();
            checks++;
            if (b_out_valid !== 1'b1 || b_out_chan !== 2'(e) || b_out_data !== 8'(16 + e)) begin
                errors++;
                $display("FAIL rr_all beat %0d got v=%b c=%0d d=%h want 1/%0d/%h", k, b_out_valid, b_out_chan, b_out_data, e, 8'(16 + e));
            end
        end
        b_in_valid = 4'h0;
        tick();
    endtask

    task automatic test_rr_skip();
        int exp_chan [7];
        exp_chan = '{1, 3, 1, 3, 1, 1, 1};
        apply_reset(1);
        b_in_valid = 4'b1010; b_out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) b_in_valid = 4'b0010;
            tick();
            checks++;
            if (b_out_valid !== 1'b1 || b_out_chan !== 2'(exp_chan[k]) || b_out_data !== 8'(16 + exp_chan[k])) begin
                errors++;
                $display("FAIL rr_skip beat %0d got v=%b c=%0d d=%h want 1/%0d", k, b_out_valid, b_out_chan, b_out_data, exp_chan[k]);
            end
        end
        b_in_valid = 4'h0;
        tick();
    endtask

    task automatic test_rr_stall();
        apply_reset(1);
        b_in_valid = 4'hF; b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (b_out_valid !== 1'b1 || b_out_chan !== 2'd0 || b_in_ready !== 4'b0000) begin
            errors++; $display("FAIL rr_stall got v=%b c=%0d rdy=%b want 1/0/0000", b_out_valid, b_out_chan, b_in_ready);
        end
        b_out_ready = 1'b1;
        #1;
        checks++;
        if (b_in_ready !== 4'b0010) begin errors++; $display("FAIL rr_stall_ptr got %b want 0010", b_in_ready); end
        tick();
        checks++;
        if (b_out_chan !== 2'd1 || b_out_data !== 8'h11) begin
            errors++; $display("FAIL rr_stall_next got c=%0d d=%h want 1/11", b_out_chan, b_out_data);
        end
        b_in_valid = 4'h0;
        tick();
    endtask

    task automatic test_n3_out_of_range();
        c_in_data = 24'h77_66_55; c_in_valid = 3'b111; c_sel = 2'd3; c_out_ready = 1'b1;
        #1;
        checks++;
        if (c_in_ready !== 3'b000) begin errors++; $display("FAIL n3_oor_ready got %b want 000", c_in_ready); end
        tick();
        tick();
        checks++;
        if (c_out_valid !== 1'b0) begin errors++; $display("FAIL n3_oor_valid got %b want 0", c_out_valid); end
        c_sel = 2'd2;
        #1;
        checks++;
        if (c_in_ready !== 3'b100) begin errors++; $display("FAIL n3_top_ready got %b want 100", c_in_ready); end
        tick();
        checks++;
        if (c_out_valid !== 1'b1 || c_out_data !== 8'h77 || c_out_chan !== 2'd2) begin
            errors++; $display("FAIL n3_top_load got v=%b d=%h c=%0d want 1/77/2", c_out_valid, c_out_data, c_out_chan);
        end
        c_in_valid = 3'b000;
        tick();
    endtask

    task automatic test_rst_mid_transfer();
        b_in_valid = 4'b0100; b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_chan !== 2'd2) begin
            errors++; $display("FAIL rst_mid_setup got v=%b c=%0d want 1/2", b_out_valid, b_out_chan);
        end
        rst = 1'b1; b_in_valid = 4'hF;
        #1;
        checks++;
        if (b_in_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_ready got %b want 0000", b_in_ready); end
        tick();
        rst = 1'b0;
        checks++;
        if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", b_out_valid); end
        b_out_ready = 1'b1;
        #1;
        checks++;
        if (b_in_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_grant got %b want 0001", b_in_ready); end
        tick();
        checks++;
        if (b_out_valid !== 1'b1 || b_out_chan !== 2'd0 || b_out_data !== 8'h10) begin
            errors++; $display("FAIL rst_mid_next got v=%b c=%0d d=%h want 1/0/10", b_out_valid, b_out_chan, b_out_data);
        end
        b_in_valid = 4'h0;
        tick();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        a_in_valid = '0; a_in_data = '0; a_sel = '0; a_out_ready = 1'b0;
        b_in_valid = '0; b_in_data = 32'h1312_1110; b_sel = '0; b_out_ready = 1'b0;
        c_in_valid = '0; c_in_data = '0; c_sel = '0; c_out_ready = 1'b0;
        test_reset();
        test_sel_basic();
        test_sel_backpressure();
        test_rr_all();
        test_rr_skip();
        test_rr_stall();
        test_n3_out_of_range();
        test_rst_mid_transfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
